vc_input_unit: RTL and testbench
================================

Name: vc_input_unit

Overview:
- Parametrised input unit for one router input port, holding NUM_VC virtual channels; each VC has a VC_DEPTH-flit FIFO and its own G/R/O state.
- Performs per-VC packet state tracking, VC-allocation request/grant capture and switch-allocation request/grant.
- Drives one registered flit per cycle to the crossbar and returns one credit upstream per dequeued flit.
- Sits between the link receiver and the router's VC/switch allocators.

Parameters:
- FLIT_SIZE, 32, flit width; type field is bits [FLIT_SIZE-1:FLIT_SIZE-HEADER_LEN].
- HEADER_LEN, 2, type-field width; encodings HEAD=2'b00, BODY=2'b01, TAIL=2'b10, SINGLE=2'b11.
- ROUTE_LEN, 3, output-port number width.
- NUM_VC, 4, virtual channels per port (power of 2, ≥2).
- VC_DEPTH, 4, FIFO slots per VC (power of 2, ≥2).
- VCW, $clog2(NUM_VC), VC index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- flit_in  in  FLIT_SIZE  incoming flit.
- valid_in  in  1  flit_in valid.
- vc_in  in  VCW  target input VC.
- route_in  in  ROUTE_LEN  output port of flit_in.
- va_req  out  NUM_VC  VC v requests an output VC.
- va_route  out  NUM_VC*ROUTE_LEN  front-flit route per VC.
- va_grant  in  NUM_VC  OVC granted to VC v.
- va_ovc  in  NUM_VC*VCW  granted OVC index per VC.
- credit_avail  in  NUM_VC  downstream (R,O) of VC v has ≥1 credit.
- sa_req  out  NUM_VC  VC v requests the switch.
- sa_grant  in  NUM_VC  switch grant, expected one-hot.
- flit_out  out  FLIT_SIZE  registered crossbar flit.
- valid_out  out  1  flit_out valid.
- out_route  out  ROUTE_LEN  output port of flit_out.
- out_ovc  out  VCW  downstream VC of flit_out.
- credit_out  out  1  one-cycle credit pulse upstream.
- credit_vc  out  VCW  VC freed by credit_out.
- vc_state  out  NUM_VC*3  G per VC.
- vc_full  out  NUM_VC  FIFO full per VC.
- err  out  2  sticky: [0] overflow write, [1] protocol violation (body/tail at front in IDLE, or non-one-hot sa_grant).

Behaviour:
- Reset (rst=0, asynchronous): all FIFOs empty; G=IDLE(0); O=all-ones; flit_out=0; valid_out=0; out_route=0; out_ovc=0; credit_out=0; credit_vc=0; err=0. va_req, sa_req and vc_full follow from the reset state and are all 0.
- G encodings: IDLE=0, WAITING_FOR_OVC=2, ACTIVE=3, WAITING_FOR_CREDITS=4.
- Write path:
  - When valid_in is high, {route_in, flit_in} is pushed into FIFO vc_in at the clock edge.
  - Full is evaluated after same-cycle dequeue: a write to a full VC is accepted if that VC dequeues in the same cycle.
  - Otherwise the flit is dropped and err[0] is set.
- Per-VC state transitions:
  - IDLE, FIFO nonempty, front HEAD/SINGLE -> WAITING_FOR_OVC.
  - IDLE, FIFO nonempty, front BODY/TAIL -> stay IDLE and set err[1].
  - WAITING_FOR_OVC: va_req=1, va_route=R of front flit. On va_grant, O<=va_ovc, and G -> ACTIVE if credit_avail else WAITING_FOR_CREDITS.
  - ACTIVE with credit_avail=0 -> WAITING_FOR_CREDITS; WAITING_FOR_CREDITS with credit_avail=1 -> ACTIVE.
  - sa_req[v] = (G==ACTIVE) & nonempty & credit_avail[v].
- Dequeue:
  - On sa_grant[v]&sa_req[v], the front flit is popped.
  - The next edge loads flit_out/out_route/out_ovc=O and sets valid_out=1, credit_out=1, credit_vc=v.
  - With no grant, valid_out=0 and credit_out=0 on the next edge (single-cycle pulses).
  - A multi-hot sa_grant serves the lowest requesting index and sets err[1].
  - A grant to a non-requesting VC is ignored.
- Packet end:
  - Popping a TAIL or SINGLE flit sets O to all-ones.
  - G then goes to WAITING_FOR_OVC if the FIFO still holds flits after this cycle's push/pop, else IDLE.
  - A body flit of the current packet arriving into an empty ACTIVE VC is legal; the VC stays ACTIVE.
- Minimum head latency: write at edge 0 -> WAITING_FOR_OVC at edge 1 -> (grant) ACTIVE at edge 2 -> (sa_grant) valid_out at edge 3.
- VCs are fully independent; a write to VC a and a dequeue from VC b in the same cycle are both serviced.
- FIFO pointers wrap modulo VC_DEPTH. Occupancy counts run 0..VC_DEPTH, so counter width is $clog2(VC_DEPTH)+1.

Test Plan:
- Single-flit packet: NUM_VC=2, SINGLE flit 0xC0000005 on VC1, route 3; grant OVC 1 in cycle 1; sa_grant=2'b10 in cycle 2 -> edge 3 gives flit_out=0xC0000005, out_route=3, out_ovc=1, credit_out=1, credit_vc=1; VC1 returns to IDLE.
- 4-flit packet on VC0 with credit_avail[0] low for 3 cycles mid-packet -> G=4 during the stall, no sa_req, no flit loss; flits exit in order HEAD, BODY, BODY, TAIL.
- Fill VC0 with 4 flits, write a 5th with no dequeue -> dropped, err[0]=1, vc_full[0]=1. Repeat the 5th write with a same-cycle dequeue -> accepted, err unchanged.
- Back-to-back packets: TAIL followed by HEAD queued in VC1 -> after the TAIL pops, G goes directly to 2, va_req[1]=1 the next cycle, O=all-ones.
- Interleaving: packets on VC0 and VC1 with alternating sa_grant -> valid_out every cycle, credit_vc alternating 0,1. sa_grant=2'b11 -> VC0 served and err[1]=1.
- Reset: assert rst low mid-packet, asynchronously between edges -> all outputs and FIFOs cleared immediately; after release, a fresh HEAD is accepted normally.

Source files
------------

// File: rtl/vc_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : vc_input_unit
// Purpose  : Router input port with NUM_VC per-VC FIFOs, G/R/O packet state,
//            VC/switch allocation handshakes and a registered crossbar output.
// Revision : 1.0 - initial release
// ============================================================================
module vc_input_unit #(
   parameter int FLIT_SIZE  = 32,
   parameter int HEADER_LEN = 2,
   parameter int ROUTE_LEN  = 3,
   parameter int NUM_VC     = 4,
   parameter int VC_DEPTH   = 4,
   parameter int VCW        = $clog2(NUM_VC)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FLIT_SIZE-1:0]      flit_in,
   input  logic                      valid_in,
   input  logic [VCW-1:0]            vc_in,
   input  logic [ROUTE_LEN-1:0]      route_in,
   output logic [NUM_VC-1:0]         va_req,
   output logic [NUM_VC*ROUTE_LEN-1:0] va_route,
   input  logic [NUM_VC-1:0]         va_grant,
   input  logic [NUM_VC*VCW-1:0]     va_ovc,
   input  logic [NUM_VC-1:0]         credit_avail,
   output logic [NUM_VC-1:0]         sa_req,
   input  logic [NUM_VC-1:0]         sa_grant,
   output logic [FLIT_SIZE-1:0]      flit_out,
   output logic                      valid_out,
   output logic [ROUTE_LEN-1:0]      out_route,
   output logic [VCW-1:0]            out_ovc,
   output logic                      credit_out,
   output logic [VCW-1:0]            credit_vc,
   output logic [NUM_VC*3-1:0]       vc_state,
   output logic [NUM_VC-1:0]         vc_full,
   output logic [1:0]                err
);

   localparam int c_PW = $clog2(VC_DEPTH);
   localparam int c_CW = c_PW + 1;
   localparam int c_DW = ROUTE_LEN + FLIT_SIZE;
   localparam logic [HEADER_LEN-1:0] c_HEAD   = HEADER_LEN'(0);
   localparam logic [HEADER_LEN-1:0] c_TAIL   = HEADER_LEN'(2);
   localparam logic [HEADER_LEN-1:0] c_SINGLE = HEADER_LEN'(3);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_OVC  = 3'd2,
      S_ACTIVE    = 3'd3,
      S_WAIT_CRED = 3'd4
   } state_t;

   logic [c_DW-1:0]    w_front [NUM_VC];
   logic [VCW-1:0]     w_ovc   [NUM_VC];
   logic [NUM_VC-1:0]  w_push;
   logic [NUM_VC-1:0]  w_pop;
   logic [NUM_VC-1:0]  w_perr;
   logic [NUM_VC-1:0]  w_gnt;
   logic               w_deq_vld;
   logic [VCW-1:0]     w_deq_vc;
   logic               w_multi;
   logic               w_ovf;
   logic [1:0]         r_err;

   assign w_gnt   = sa_grant & sa_req;
   assign w_multi = |(sa_grant & (sa_grant - NUM_VC'(1)));
   assign w_ovf   = valid_in & ~(|w_push);
   assign err     = r_err;

   // Descending scan so the lowest requesting index wins a multi-hot grant.
   always_comb begin
      w_deq_vld = 1'b0;
      w_deq_vc  = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         if (w_gnt[i]) begin
            w_deq_vld = 1'b1;
            w_deq_vc  = VCW'(i);
         end
      end
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [c_DW-1:0]       r_mem [VC_DEPTH];
      logic [c_PW-1:0]       r_rd;
      logic [c_PW-1:0]       r_wr;
      logic [c_CW-1:0]       r_cnt;
      logic [c_CW-1:0]       w_cnt_nxt;
      logic [VCW-1:0]        r_o;
      state_t                r_g;
      logic [HEADER_LEN-1:0] w_type;
      logic                  w_empty;
      logic                  w_is_head;
      logic                  w_is_last;

      assign w_front[v]  = r_mem[r_rd];
      assign w_ovc[v]    = r_o;
      assign w_type      = r_mem[r_rd][FLIT_SIZE-1 -: HEADER_LEN];
      assign w_empty     = (r_cnt == '0);
      assign w_is_head   = (w_type == c_HEAD) || (w_type == c_SINGLE);
      assign w_is_last   = (w_type == c_TAIL) || (w_type == c_SINGLE);
      assign vc_full[v]  = (r_cnt == c_CW'(VC_DEPTH));
      assign w_pop[v]    = w_deq_vld && (w_deq_vc == VCW'(v));
      // A full VC still accepts a write when it drains in the same cycle.
      assign w_push[v]   = valid_in && (vc_in == VCW'(v)) && (!vc_full[v] || w_pop[v]);
      assign w_cnt_nxt   = r_cnt + c_CW'(w_push[v]) - c_CW'(w_pop[v]);
      assign w_perr[v]   = (r_g == S_IDLE) && !w_empty && !w_is_head;
      assign va_req[v]   = (r_g == S_WAIT_OVC);
      assign sa_req[v]   = (r_g == S_ACTIVE) && !w_empty && credit_avail[v];
      assign va_route[v*ROUTE_LEN +: ROUTE_LEN] = r_mem[r_rd][c_DW-1 -: ROUTE_LEN];
      assign vc_state[v*3 +: 3] = r_g;

      always_ff @(posedge clk) begin
         if (w_push[v]) r_mem[r_wr] <= {route_in, flit_in};
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_o   <= '1;
            r_g   <= S_IDLE;
         end else begin
            if (w_push[v]) r_wr <= r_wr + c_PW'(1);
            if (w_pop[v])  r_rd <= r_rd + c_PW'(1);
            r_cnt <= w_cnt_nxt;
            case (r_g)
               S_IDLE: begin
                  if (!w_empty && w_is_head) r_g <= S_WAIT_OVC;
               end
               S_WAIT_OVC: begin
                  if (va_grant[v]) begin
                     r_o <= va_ovc[v*VCW +: VCW];
                     r_g <= credit_avail[v] ? S_ACTIVE : S_WAIT_CRED;
                  end
               end
               S_ACTIVE: begin
                  if (w_pop[v]) begin
                     if (w_is_last) begin
                        r_o <= '1;
                        r_g <= (w_cnt_nxt != '0) ? S_WAIT_OVC : S_IDLE;
                     end
                  end else if (!credit_avail[v]) begin
                     r_g <= S_WAIT_CRED;
                  end
               end
               S_WAIT_CRED: begin
                  if (credit_avail[v]) r_g <= S_ACTIVE;
               end
               default: r_g <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flit_out   <= '0;
         valid_out  <= 1'b0;
         out_route  <= '0;
         out_ovc    <= '0;
         credit_out <= 1'b0;
         credit_vc  <= '0;
         r_err      <= '0;
      end else begin
         valid_out  <= w_deq_vld;
         credit_out <= w_deq_vld;
         if (w_deq_vld) begin
            flit_out  <= w_front[w_deq_vc][FLIT_SIZE-1:0];
            out_route <= w_front[w_deq_vc][c_DW-1 -: ROUTE_LEN];
            out_ovc   <= w_ovc[w_deq_vc];
            credit_vc <= w_deq_vc;
         end
         if (w_ovf) r_err[0] <= 1'b1;
         if ((|w_perr) || w_multi) r_err[1] <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vc_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_input_unit
// Purpose  : Directed self-checking bench for vc_input_unit (NUM_VC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_input_unit;

   logic        clk;
   logic        rst;
   logic [31:0] flit_in;
   logic        valid_in;
   logic [0:0]  vc_in;
   logic [2:0]  route_in;
   logic [1:0]  va_req;
   logic [5:0]  va_route;
   logic [1:0]  va_grant;
   logic [1:0]  va_ovc;
   logic [1:0]  credit_avail;
   logic [1:0]  sa_req;
   logic [1:0]  sa_grant;
   logic [31:0] flit_out;
   logic        valid_out;
   logic [2:0]  out_route;
   logic [0:0]  out_ovc;
   logic        credit_out;
   logic [0:0]  credit_vc;
   logic [5:0]  vc_state;
   logic [1:0]  vc_full;
   logic [1:0]  err;

   int n_checks = 0;
   int n_errors = 0;

   vc_input_unit #(
      .FLIT_SIZE(32), .HEADER_LEN(2), .ROUTE_LEN(3), .NUM_VC(2), .VC_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
      .vc_in(vc_in), .route_in(route_in), .va_req(va_req), .va_route(va_route),
      .va_grant(va_grant), .va_ovc(va_ovc), .credit_avail(credit_avail),
      .sa_req(sa_req), .sa_grant(sa_grant), .flit_out(flit_out),
      .valid_out(valid_out), .out_route(out_route), .out_ovc(out_ovc),
      .credit_out(credit_out), .credit_vc(credit_vc), .vc_state(vc_state),
      .vc_full(vc_full), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, step past the edge, then drop the pulses.
   task automatic cyc(input logic v, input logic [0:0] vc, input logic [31:0] f,
                      input logic [2:0] r, input logic [1:0] vag,
                      input logic [1:0] vovc, input logic [1:0] sag);
      valid_in = v; vc_in = vc; flit_in = f; route_in = r;
      va_grant = vag; va_ovc = vovc; sa_grant = sag;
      @(posedge clk); #1;
      valid_in = 1'b0; va_grant = '0; sa_grant = '0;
   endtask

   task automatic push(input logic [0:0] vc, input logic [31:0] f, input logic [2:0] r);
      cyc(1'b1, vc, f, r, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 3'd0, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic vgrant(input logic [1:0] g, input logic [1:0] o);
      cyc(1'b0, 1'b0, 32'h0, 3'd0, g, o, 2'b00);
   endtask

   task automatic sgrant(input logic [1:0] g);
      cyc(1'b0, 1'b0, 32'h0, 3'd0, 2'b00, 2'b00, g);
   endtask

   initial begin
      rst = 1'b0; valid_in = 1'b0; vc_in = '0; flit_in = '0; route_in = '0;
      va_grant = '0; va_ovc = '0; sa_grant = '0; credit_avail = 2'b11;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      check("rst_valid_out", valid_out, 0);
      check("rst_credit_out", credit_out, 0);
      check("rst_flit_out", flit_out, 0);
      check("rst_vc_state", vc_state, 0);
      check("rst_va_req", va_req, 0);
      check("rst_sa_req", sa_req, 0);
      check("rst_vc_full", vc_full, 0);
      check("rst_err", err, 0);

      // Single-flit packet on VC1, minimum latency
      push(1'b1, 32'hC0000005, 3'd3);
      check("t1_idle_after_write", vc_state, 6'o00);
      idle();
      check("t1_state_wait", vc_state, 6'o20);
      check("t1_va_req", va_req, 2'b10);
      check("t1_va_route", va_route[5:3], 3);
      vgrant(2'b10, 2'b10);
      check("t1_state_active", vc_state, 6'o30);
      check("t1_sa_req", sa_req, 2'b10);
      sgrant(2'b10);
      check("t1_valid_out", valid_out, 1);
      check("t1_flit_out", flit_out, 32'hC0000005);
      check("t1_out_route", out_route, 3);
      check("t1_out_ovc", out_ovc, 1);
      check("t1_credit_out", credit_out, 1);
      check("t1_credit_vc", credit_vc, 1);
      check("t1_back_idle", vc_state, 6'o00);
      idle();
      check("t1_valid_pulse", valid_out, 0);
      check("t1_credit_pulse", credit_out, 0);

      // 4-flit packet on VC0 with a 3-cycle credit stall
      push(1'b0, 32'h00000011, 3'd5);
      push(1'b0, 32'h40000022, 3'd5);
      push(1'b0, 32'h40000033, 3'd5);
      push(1'b0, 32'h80000044, 3'd5);
      check("t2_full", vc_full, 2'b01);
      vgrant(2'b01, 2'b00);
      check("t2_active", vc_state[2:0], 3);
      sgrant(2'b01);
      check("t2_head", flit_out, 32'h00000011);
      check("t2_head_route", out_route, 5);
      check("t2_head_ovc", out_ovc, 0);
      credit_avail = 2'b10;
      for (int i = 0; i < 3; i++) begin
         sgrant(2'b01);
         check("t2_stall_state", vc_state[2:0], 4);
         check("t2_stall_sa_req", sa_req[0], 0);
         check("t2_stall_valid", valid_out, 0);
      end
      credit_avail = 2'b11;
      idle();
      check("t2_resume_state", vc_state[2:0], 3);
      check("t2_resume_sa_req", sa_req, 2'b01);
      sgrant(2'b01);
      check("t2_body1", flit_out, 32'h40000022);
      sgrant(2'b01);
      check("t2_body2", flit_out, 32'h40000033);
      sgrant(2'b01);
      check("t2_tail", flit_out, 32'h80000044);
      check("t2_tail_valid", valid_out, 1);
      check("t2_idle", vc_state[2:0], 0);
      check("t2_err", err, 0);

      // Overflow, then full-plus-dequeue acceptance
      push(1'b0, 32'h00000101, 3'd2);
      push(1'b0, 32'h40000102, 3'd2);
      push(1'b0, 32'h40000103, 3'd2);
      push(1'b0, 32'h80000104, 3'd2);
      push(1'b0, 32'h00000105, 3'd2);
      check("t3_ovf_err", err, 2'b01);
      check("t3_ovf_full", vc_full, 2'b01);
      vgrant(2'b01, 2'b00);
      cyc(1'b1, 1'b0, 32'hC0000666, 3'd2, 2'b00, 2'b00, 2'b01);
      check("t3_pushpop_err", err, 2'b01);
      check("t3_pushpop_full", vc_full, 2'b01);
      check("t3_pushpop_out", flit_out, 32'h00000101);
      sgrant(2'b01);
      check("t3_out2", flit_out, 32'h40000102);
      sgrant(2'b01);
      check("t3_out3", flit_out, 32'h40000103);
      sgrant(2'b01);
      check("t3_out4", flit_out, 32'h80000104);
      check("t3_next_wait", vc_state[2:0], 2);
      check("t3_next_va_req", va_req, 2'b01);
      vgrant(2'b01, 2'b00);
      sgrant(2'b01);
      check("t3_out5", flit_out, 32'hC0000666);
      check("t3_idle", vc_state, 6'o00);

      // Back-to-back TAIL then HEAD on VC1
      push(1'b1, 32'h00000A01, 3'd2);
      push(1'b1, 32'h80000A02, 3'd2);
      push(1'b1, 32'h00000B01, 3'd6);
      vgrant(2'b10, 2'b00);
      sgrant(2'b10);
      check("t4_head", flit_out, 32'h00000A01);
      sgrant(2'b10);
      check("t4_tail", flit_out, 32'h80000A02);
      check("t4_tail_ovc", out_ovc, 0);
      check("t4_wait", vc_state, 6'o20);
      check("t4_va_req", va_req, 2'b10);
      check("t4_va_route", va_route[5:3], 6);

      // Interleaving VC0/VC1 including a multi-hot grant
      push(1'b0, 32'h00000C01, 3'd1);
      push(1'b0, 32'h80000C02, 3'd1);
      push(1'b1, 32'h80000B02, 3'd6);
      vgrant(2'b11, 2'b01);
      check("t5_both_active", vc_state, 6'o33);
      check("t5_sa_req", sa_req, 2'b11);
      sgrant(2'b11);
      check("t5_multi_flit", flit_out, 32'h00000C01);
      check("t5_multi_vc", credit_vc, 0);
      check("t5_multi_ovc", out_ovc, 1);
      check("t5_multi_err", err, 2'b11);
      sgrant(2'b10);
      check("t5_valid1", valid_out, 1);
      check("t5_flit1", flit_out, 32'h00000B01);
      check("t5_vc1", credit_vc, 1);
      check("t5_route1", out_route, 6);
      sgrant(2'b01);
      check("t5_valid2", valid_out, 1);
      check("t5_flit2", flit_out, 32'h80000C02);
      check("t5_vc2", credit_vc, 0);
      sgrant(2'b10);
      check("t5_valid3", valid_out, 1);
      check("t5_flit3", flit_out, 32'h80000B02);
      check("t5_vc3", credit_vc, 1);
      check("t5_idle", vc_state, 6'o00);

      // Asynchronous reset mid-packet
      push(1'b0, 32'h00000D01, 3'd3);
      push(1'b0, 32'h40000D02, 3'd3);
      vgrant(2'b01, 2'b00);
      sgrant(2'b01);
      check("t6_pre_valid", valid_out, 1);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_valid", valid_out, 0);
      check("t6_rst_credit", credit_out, 0);
      check("t6_rst_flit", flit_out, 0);
      check("t6_rst_state", vc_state, 0);
      check("t6_rst_err", err, 0);
      check("t6_rst_sa_req", sa_req, 0);
      #2 rst = 1'b1;
      push(1'b0, 32'h00000E01, 3'd4);
      idle();
      check("t6_fresh_wait", vc_state, 6'o02);
      vgrant(2'b01, 2'b00);
      sgrant(2'b01);
      check("t6_fresh_flit", flit_out, 32'h00000E01);
      check("t6_fresh_route", out_route, 4);
      check("t6_fresh_ovc", out_ovc, 0);
      check("t6_fresh_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
